// File: rtl/conv3d_pkg.sv
// Shared definitions for the conv3d layer sequencer: FSM states, read-port
// select codes and the start-configuration validity check.
package conv3d_pkg;

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_WREQ  = 4'd1,
        S_WWAIT = 4'd2,
        S_XREQ  = 4'd3,
        S_XWAIT = 4'd4,
        S_PE    = 4'd5,
        S_YREQ  = 4'd6,
        S_YWAIT = 4'd7,
        S_FIN   = 4'd8
    } state_t;

    // rd_sel codes: which buffer the read burst fills
    localparam logic SEL_WEIGHT  = 1'b0;
    localparam logic SEL_FEATURE = 1'b1;

    // A layer run needs at least one row and non-empty row bursts
    function automatic logic cfg_valid(
        input logic [8:0]  height_out,
        input logic [17:0] length_in,
        input logic [17:0] length_out
    );
        return (height_out != 9'd0) && (length_in != 18'd0) && (length_out != 18'd0);
    endfunction

endpackage

// File: rtl/conv3d_req_hold.sv
// Request/acknowledge holder: raises req one cycle after launch, captures the
// payload, and keeps both stable until ack is sampled with req high.
module conv3d_req_hold #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         launch,
    input  logic [W-1:0] payload_in,
    input  logic         ack,
    output logic         req,
    output logic [W-1:0] payload
);

    logic         req_reg;
    logic [W-1:0] payload_reg;

    // Hold the request until accepted; a launch only takes effect while idle
    always_ff @(posedge clk) begin
        if (!rst) begin
            req_reg     <= 1'b0;
            payload_reg <= '0;
        end else if (req_reg) begin
            if (ack) begin
                req_reg <= 1'b0;
            end
        end else if (launch) begin
            req_reg     <= 1'b1;
            payload_reg <= payload_in;
        end
    end

    assign req     = req_reg;
    assign payload = payload_reg;

endmodule

// File: rtl/conv3d_seq.sv
// Layer sequencer for a 3D convolution engine: optional weight prefetch, then
// per output row: read input row, run the PE array, write output row.
module conv3d_seq
    import conv3d_pkg::*;
#(
    parameter int AW = 30
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cfg_ena,
    input  logic          cfg_prefetch,
    input  logic [AW-1:0] cfg_waddr,
    input  logic [7:0]    cfg_length_w,
    input  logic [AW-1:0] cfg_xbase,
    input  logic [AW-1:0] cfg_ybase,
    input  logic [AW-1:0] cfg_xoffset,
    input  logic [AW-1:0] cfg_yoffset,
    input  logic [8:0]    cfg_height_out,
    input  logic [17:0]   cfg_length_in,
    input  logic [17:0]   cfg_length_out,
    output logic          rd_req,
    output logic [AW-1:0] rd_addr,
    output logic [17:0]   rd_len,
    output logic          rd_sel,
    input  logic          rd_ack,
    input  logic          rd_done,
    output logic          wr_req,
    output logic [AW-1:0] wr_addr,
    output logic [17:0]   wr_len,
    input  logic          wr_ack,
    input  logic          wr_done,
    output logic          pe_start,
    input  logic          pe_done,
    output logic          busy,
    output logic          irq_done,
    output logic          err_cfg
);

    localparam int RW = 1 + AW + 18;
    localparam int WW = AW + 18;

    state_t        state_reg, state_next;
    logic          pending_reg;
    logic [AW-1:0] waddr_reg, x_ptr_reg, y_ptr_reg, xoffset_reg, yoffset_reg;
    logic [7:0]    length_w_reg;
    logic [8:0]    height_reg, row_reg;
    logic [17:0]   length_in_reg, length_out_reg;
    logic          err_reg, pe_start_reg, irq_reg;

    logic          cfg_ok, err_next;
    logic          w_finish, x_finish, row_done, last_row;
    logic          rd_launch, wr_launch;
    logic [RW-1:0] rd_payload_in, rd_payload;
    logic [WW-1:0] wr_payload_in, wr_payload;

    assign cfg_ok   = cfg_valid(cfg_height_out, cfg_length_in, cfg_length_out);
    assign last_row = ((row_reg + 9'd1) == height_reg);

    // Completion events; ack+done together lets a REQ state skip its WAIT
    assign w_finish = ((state_reg == S_WREQ) && rd_req && rd_ack && rd_done) ||
                      ((state_reg == S_WWAIT) && rd_done);
    assign x_finish = ((state_reg == S_XREQ) && rd_req && rd_ack && rd_done) ||
                      ((state_reg == S_XWAIT) && rd_done);
    assign row_done = ((state_reg == S_YREQ) && wr_req && wr_ack && wr_done) ||
                      ((state_reg == S_YWAIT) && wr_done);

    // Any start pulse outside IDLE is rejected; in IDLE only a bad layer start is
    assign err_next = (state_reg == S_IDLE) ? (cfg_ena && !cfg_ok)
                                            : (cfg_ena || cfg_prefetch);

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: begin
                if (cfg_prefetch)          state_next = S_WREQ;
                else if (cfg_ena && cfg_ok) state_next = S_XREQ;
            end
            S_WREQ: begin
                if (w_finish)               state_next = pending_reg ? S_XREQ : S_IDLE;
                else if (rd_req && rd_ack)  state_next = S_WWAIT;
            end
            S_WWAIT: begin
                if (w_finish)               state_next = pending_reg ? S_XREQ : S_IDLE;
            end
            S_XREQ: begin
                if (x_finish)               state_next = S_PE;
                else if (rd_req && rd_ack)  state_next = S_XWAIT;
            end
            S_XWAIT: begin
                if (x_finish)               state_next = S_PE;
            end
            S_PE: begin
                if (pe_done)                state_next = S_YREQ;
            end
            S_YREQ: begin
                if (row_done)               state_next = last_row ? S_FIN : S_XREQ;
                else if (wr_req && wr_ack)  state_next = S_YWAIT;
            end
            S_YWAIT: begin
                if (row_done)               state_next = last_row ? S_FIN : S_XREQ;
            end
            S_FIN:   state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // State, configuration snapshot, row pointers and output pulses
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg      <= S_IDLE;
            pending_reg    <= 1'b0;
            waddr_reg      <= '0;
            length_w_reg   <= '0;
            height_reg     <= '0;
            length_in_reg  <= '0;
            length_out_reg <= '0;
            xoffset_reg    <= '0;
            yoffset_reg    <= '0;
            x_ptr_reg      <= '0;
            y_ptr_reg      <= '0;
            row_reg        <= '0;
            err_reg        <= 1'b0;
            pe_start_reg   <= 1'b0;
            irq_reg        <= 1'b0;
        end else begin
            state_reg    <= state_next;
            err_reg      <= err_next;
            pe_start_reg <= (state_next == S_PE) && (state_reg != S_PE);
            irq_reg      <= (state_next == S_FIN);

            if (state_reg == S_IDLE) begin
                if (cfg_prefetch || (cfg_ena && cfg_ok)) begin
                    waddr_reg    <= cfg_waddr;
                    length_w_reg <= cfg_length_w;
                end
                if (cfg_ena && cfg_ok) begin
                    height_reg     <= cfg_height_out;
                    length_in_reg  <= cfg_length_in;
                    length_out_reg <= cfg_length_out;
                    xoffset_reg    <= cfg_xoffset;
                    yoffset_reg    <= cfg_yoffset;
                    x_ptr_reg      <= cfg_xbase;
                    y_ptr_reg      <= cfg_ybase;
                    row_reg        <= 9'd0;
                    pending_reg    <= cfg_prefetch;
                end
            end else if (w_finish) begin
                pending_reg <= 1'b0;
            end

            // Strided row advance; AW-bit adders wrap modulo 2^AW
            if (row_done) begin
                x_ptr_reg <= x_ptr_reg + xoffset_reg;
                y_ptr_reg <= y_ptr_reg + yoffset_reg;
                row_reg   <= row_reg + 9'd1;
            end
        end
    end

    assign rd_launch     = (state_reg == S_WREQ) || (state_reg == S_XREQ);
    assign rd_payload_in = (state_reg == S_WREQ)
                         ? {SEL_WEIGHT, waddr_reg, {10'd0, length_w_reg}}
                         : {SEL_FEATURE, x_ptr_reg, length_in_reg};
    assign wr_launch     = (state_reg == S_YREQ);
    assign wr_payload_in = {y_ptr_reg, length_out_reg};

    conv3d_req_hold #(.W(RW)) u_rd_hold (
        .clk        (clk),
        .rst        (rst),
        .launch     (rd_launch),
        .payload_in (rd_payload_in),
        .ack        (rd_ack),
        .req        (rd_req),
        .payload    (rd_payload)
    );

    conv3d_req_hold #(.W(WW)) u_wr_hold (
        .clk        (clk),
        .rst        (rst),
        .launch     (wr_launch),
        .payload_in (wr_payload_in),
        .ack        (wr_ack),
        .req        (wr_req),
        .payload    (wr_payload)
    );

    assign {rd_sel, rd_addr, rd_len} = rd_payload;
    assign {wr_addr, wr_len}         = wr_payload;

    assign pe_start = pe_start_reg;
    assign irq_done = irq_reg;
    assign err_cfg  = err_reg;
    assign busy     = (state_reg != S_IDLE);

endmodule

// File: tb/tb_conv3d_seq.sv
// Directed testbench for conv3d_seq with memory and PE responders.
module tb_conv3d_seq;

    localparam int AW = 30;

    logic          clk = 1'b0;
    logic          rst;
    logic          cfg_ena, cfg_prefetch;
    logic [AW-1:0] cfg_waddr, cfg_xbase, cfg_ybase, cfg_xoffset, cfg_yoffset;
    logic [7:0]    cfg_length_w;
    logic [8:0]    cfg_height_out;
    logic [17:0]   cfg_length_in, cfg_length_out;
    logic          rd_req, rd_sel, rd_ack, rd_done;
    logic [AW-1:0] rd_addr;
    logic [17:0]   rd_len;
    logic          wr_req, wr_ack, wr_done;
    logic [AW-1:0] wr_addr;
    logic [17:0]   wr_len;
    logic          pe_start, pe_done, busy, irq_done, err_cfg;

    always #5 clk = ~clk;

    conv3d_seq #(.AW(AW)) dut (
        .clk(clk), .rst(rst),
        .cfg_ena(cfg_ena), .cfg_prefetch(cfg_prefetch),
        .cfg_waddr(cfg_waddr), .cfg_length_w(cfg_length_w),
        .cfg_xbase(cfg_xbase), .cfg_ybase(cfg_ybase),
        .cfg_xoffset(cfg_xoffset), .cfg_yoffset(cfg_yoffset),
        .cfg_height_out(cfg_height_out),
        .cfg_length_in(cfg_length_in), .cfg_length_out(cfg_length_out),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_len(rd_len), .rd_sel(rd_sel),
        .rd_ack(rd_ack), .rd_done(rd_done),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_len(wr_len),
        .wr_ack(wr_ack), .wr_done(wr_done),
        .pe_start(pe_start), .pe_done(pe_done),
        .busy(busy), .irq_done(irq_done), .err_cfg(err_cfg)
    );

    int checks = 0;
    int errors = 0;

    // Responder controls
    int rd_ack_dly = 2, rd_done_dly = 2, wr_ack_dly = 2, wr_done_dly = 2, pe_dly = 1;
    bit rd_stall = 1'b0, wr_nodone = 1'b0;

    // Monitor state
    int n_rd = 0, n_wr = 0, n_pe = 0, n_irq = 0, n_err = 0, n_busy = 0, n_unstable = 0;
    logic [AW-1:0] rd_addr_log [0:63];
    logic          rd_sel_log  [0:63];
    logic [17:0]   rd_len_log  [0:63];
    logic [AW-1:0] wr_addr_log [0:63];
    logic [17:0]   wr_len_log  [0:63];
    logic          rd_req_q = 1'b0, wr_req_q = 1'b0;
    logic [AW+18:0] rd_cap;
    logic [AW+17:0] wr_cap;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Read-side memory model
    initial begin : rd_responder
        int cnt;
        int phase;
        cnt = 0; phase = 0; rd_ack = 1'b0; rd_done = 1'b0;
        forever begin
            @(negedge clk);
            rd_ack = 1'b0; rd_done = 1'b0;
            if (rst !== 1'b1) begin
                cnt = 0; phase = 0;
            end else if (phase == 0) begin
                if (rd_req === 1'b1 && !rd_stall) begin
                    cnt++;
                    if (cnt >= rd_ack_dly) begin
                        rd_ack = 1'b1; cnt = 0;
                        if (rd_done_dly == 0) rd_done = 1'b1;
                        else phase = 1;
                    end
                end
            end else begin
                cnt++;
                if (cnt >= rd_done_dly) begin
                    rd_done = 1'b1; cnt = 0; phase = 0;
                end
            end
        end
    end

    // Write-side memory model
    initial begin : wr_responder
        int cnt;
        int phase;
        cnt = 0; phase = 0; wr_ack = 1'b0; wr_done = 1'b0;
        forever begin
            @(negedge clk);
            wr_ack = 1'b0; wr_done = 1'b0;
            if (rst !== 1'b1) begin
                cnt = 0; phase = 0;
            end else if (phase == 0) begin
                if (wr_req === 1'b1) begin
                    cnt++;
                    if (cnt >= wr_ack_dly) begin
                        wr_ack = 1'b1; cnt = 0;
                        if (wr_done_dly == 0) wr_done = 1'b1;
                        else phase = 1;
                    end
                end
            end else if (!wr_nodone) begin
                cnt++;
                if (cnt >= wr_done_dly) begin
                    wr_done = 1'b1; cnt = 0; phase = 0;
                end
            end
        end
    end

    // PE array model
    initial begin : pe_responder
        int cnt;
        bit active;
        cnt = 0; active = 1'b0; pe_done = 1'b0;
        forever begin
            @(negedge clk);
            pe_done = 1'b0;
            if (rst !== 1'b1) begin
                active = 1'b0;
            end else if (pe_start === 1'b1 && !active) begin
                if (pe_dly == 0) pe_done = 1'b1;
                else begin active = 1'b1; cnt = 0; end
            end else if (active) begin
                cnt++;
                if (cnt >= pe_dly) begin pe_done = 1'b1; active = 1'b0; end
            end
        end
    end

    // Transaction logger and pulse counters
    initial begin : monitor
        forever begin
            @(negedge clk);
            if (rd_req === 1'b1 && rd_req_q !== 1'b1) begin
                if (n_rd < 64) begin
                    rd_addr_log[n_rd] = rd_addr; rd_sel_log[n_rd] = rd_sel; rd_len_log[n_rd] = rd_len;
                end
                rd_cap = {rd_sel, rd_addr, rd_len};
                $display("rd #%0d sel=%0d addr=0x%08h len=%0d", n_rd, rd_sel, rd_addr, rd_len);
                n_rd++;
            end else if (rd_req === 1'b1 && {rd_sel, rd_addr, rd_len} !== rd_cap) begin
                n_unstable++;
            end
            if (wr_req === 1'b1 && wr_req_q !== 1'b1) begin
                if (n_wr < 64) begin
                    wr_addr_log[n_wr] = wr_addr; wr_len_log[n_wr] = wr_len;
                end
                wr_cap = {wr_addr, wr_len};
                $display("wr #%0d addr=0x%08h len=%0d", n_wr, wr_addr, wr_len);
                n_wr++;
            end else if (wr_req === 1'b1 && {wr_addr, wr_len} !== wr_cap) begin
                n_unstable++;
            end
            rd_req_q = rd_req;
            wr_req_q = wr_req;
            if (pe_start === 1'b1) n_pe++;
            if (irq_done === 1'b1) n_irq++;
            if (err_cfg === 1'b1) n_err++;
            if (busy === 1'b1) n_busy++;
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drive start pulses for one sampling edge; returns at the next negedge
    task automatic start(input bit pf, input bit en);
        cfg_prefetch = pf; cfg_ena = en;
        @(negedge clk);
        cfg_prefetch = 1'b0; cfg_ena = 1'b0;
    endtask

    task automatic set_cfg(input logic [8:0] h, input logic [AW-1:0] xb, input logic [AW-1:0] xo,
                           input logic [17:0] li, input logic [AW-1:0] yb, input logic [AW-1:0] yo,
                           input logic [17:0] lo);
        cfg_height_out = h; cfg_xbase = xb; cfg_xoffset = xo; cfg_length_in = li;
        cfg_ybase = yb; cfg_yoffset = yo; cfg_length_out = lo;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int k;
        k = 0;
        while (busy !== 1'b0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk(tag, busy, 0);
    endtask

    initial begin : main
        int b_rd, b_wr, b_pe, b_irq, b_err, b_busy, b_unst, k;

        rst = 1'b0; cfg_ena = 1'b0; cfg_prefetch = 1'b0;
        cfg_waddr = '0; cfg_length_w = '0;
        set_cfg(9'd0, '0, '0, '0, '0, '0, '0);
        tick(3);
        chk("rst_busy", busy, 0);
        chk("rst_rd_req", rd_req, 0);
        chk("rst_wr_req", wr_req, 0);
        chk("rst_rd_addr", rd_addr, 0);
        chk("rst_pulses", {pe_start, irq_done, err_cfg}, 0);
        rst = 1'b1;
        tick(2);

        // Three-row layer, fixed 2-cycle handshakes
        set_cfg(9'd3, 30'h100, 30'h40, 18'd16, 30'h8000, 30'h20, 18'd8);
        b_rd = n_rd; b_wr = n_wr; b_pe = n_pe; b_irq = n_irq; b_err = n_err; b_unst = n_unstable;
        start(1'b0, 1'b1);
        set_cfg(9'd0, '0, '0, '0, '0, '0, '0);  // snapshot must hold the run config
        chk("lat_busy", busy, 1);
        chk("lat_req_n1", rd_req, 0);
        tick(1);
        chk("lat_req_n2", rd_req, 1);
        chk("lat_addr", rd_addr, 30'h100);
        chk("lat_sel", rd_sel, 1);
        chk("lat_len", rd_len, 16);
        wait_idle("t1_idle", 500);
        tick(2);
        chk("t1_nrd", n_rd - b_rd, 3);
        chk("t1_addr0", rd_addr_log[b_rd], 30'h100);
        chk("t1_addr1", rd_addr_log[b_rd + 1], 30'h140);
        chk("t1_addr2", rd_addr_log[b_rd + 2], 30'h180);
        chk("t1_wr_addr2", wr_addr_log[b_wr + 2], 30'h8040);
        chk("t1_wr_len", wr_len_log[b_wr], 8);
        chk("t1_npe", n_pe - b_pe, 3);
        chk("t1_nirq", n_irq - b_irq, 1);
        chk("t1_nerr", n_err - b_err, 0);
        chk("t1_stable", n_unstable - b_unst, 0);

        // Prefetch and start in the same cycle
        cfg_waddr = 30'h2000; cfg_length_w = 8'd9;
        set_cfg(9'd1, 30'h500, 30'h40, 18'd4, 30'h9000, 30'h20, 18'd4);
        b_rd = n_rd; b_irq = n_irq; b_err = n_err;
        start(1'b1, 1'b1);
        wait_idle("t2_idle", 500);
        tick(2);
        chk("t2_nrd", n_rd - b_rd, 2);
        chk("t2_sel0", rd_sel_log[b_rd], 0);
        chk("t2_addr0", rd_addr_log[b_rd], 30'h2000);
        chk("t2_len0", rd_len_log[b_rd], 9);
        chk("t2_sel1", rd_sel_log[b_rd + 1], 1);
        chk("t2_addr1", rd_addr_log[b_rd + 1], 30'h500);
        chk("t2_nirq", n_irq - b_irq, 1);
        chk("t2_nerr", n_err - b_err, 0);

        // Address wrap with ack+done together and same-cycle pe_done
        rd_done_dly = 0; wr_done_dly = 0; pe_dly = 0;
        set_cfg(9'd2, 30'h3FFFFFC0, 30'h40, 18'd8, 30'h0, 30'h4, 18'd4);
        b_rd = n_rd; b_pe = n_pe; b_irq = n_irq;
        start(1'b0, 1'b1);
        wait_idle("t3_idle", 500);
        tick(2);
        chk("t3_nrd", n_rd - b_rd, 2);
        chk("t3_addr0", rd_addr_log[b_rd], 30'h3FFFFFC0);
        chk("t3_addr1_wrap", rd_addr_log[b_rd + 1], 30'h0);
        chk("t3_npe", n_pe - b_pe, 2);
        chk("t3_nirq", n_irq - b_irq, 1);
        rd_done_dly = 2; wr_done_dly = 2; pe_dly = 1;

        // Invalid configurations
        set_cfg(9'd0, 30'h100, 30'h40, 18'd16, 30'h8000, 30'h20, 18'd8);
        b_rd = n_rd; b_busy = n_busy; b_err = n_err;
        start(1'b0, 1'b1);
        chk("t4_err_h0", err_cfg, 1);
        tick(6);
        chk("t4_busy_cnt", n_busy - b_busy, 0);
        chk("t4_nrd", n_rd - b_rd, 0);
        chk("t4_nerr", n_err - b_err, 1);
        set_cfg(9'd1, 30'h100, 30'h40, 18'd0, 30'h8000, 30'h20, 18'd8);
        start(1'b0, 1'b1);
        chk("t4_err_li0", err_cfg, 1);
        tick(3);
        chk("t4_busy_li0", busy, 0);

        // Stalled ack: request must hold; extra starts are rejected
        rd_stall = 1'b1;
        set_cfg(9'd1, 30'h700, 30'h40, 18'd16, 30'hA000, 30'h20, 18'd8);
        b_rd = n_rd; b_irq = n_irq; b_unst = n_unstable;
        start(1'b0, 1'b1);
        tick(50);
        chk("t5_req_held", rd_req, 1);
        chk("t5_addr_held", rd_addr, 30'h700);
        chk("t5_stable", n_unstable - b_unst, 0);
        start(1'b0, 1'b1);
        chk("t5_err_ena", err_cfg, 1);
        start(1'b1, 1'b0);
        chk("t5_err_pf", err_cfg, 1);
        rd_stall = 1'b0;
        wait_idle("t5_idle", 500);
        tick(2);
        chk("t5_nrd", n_rd - b_rd, 1);
        chk("t5_nirq", n_irq - b_irq, 1);

        // Reset while waiting for the second row's write completion
        set_cfg(9'd2, 30'h100, 30'h40, 18'd16, 30'hB000, 30'h20, 18'd8);
        b_wr = n_wr; b_irq = n_irq;
        start(1'b0, 1'b1);
        k = 0;
        while (n_wr < b_wr + 2 && k < 300) begin @(negedge clk); k++; end
        chk("t6_reach_row1", n_wr - b_wr, 2);
        wr_nodone = 1'b1;
        k = 0;
        while (wr_req === 1'b1 && k < 50) begin @(negedge clk); k++; end
        chk("t6_acked", wr_req, 0);
        rst = 1'b0;
        tick(1);
        chk("t6_busy", busy, 0);
        chk("t6_reqs", {rd_req, wr_req}, 0);
        chk("t6_addrs", {rd_addr, wr_addr}, 0);
        chk("t6_pulses", {pe_start, irq_done, err_cfg}, 0);
        tick(1);
        rst = 1'b1;
        wr_nodone = 1'b0;
        tick(6);
        chk("t6_no_irq", n_irq - b_irq, 0);
        chk("t6_idle", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
